// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer with a circular return-address stack.
//
// Next-PC priority (highest first): stall, ret, call, jump, pcsrc, sequential.
// The return-address stack is a circular buffer. A call made while the stack
// is full overwrites the oldest entry, so the most recent RAS_DEPTH return
// addresses stay retrievable in LIFO order.
//
// Ports:
//   clk       - single clock, rising edge
//   reset     - synchronous, active-high reset
//   stall     - hold pc, stack and flags this cycle
//   pcsrc     - conditional branch taken (pcplus + signimm*2)
//   jump      - jump to zero-extended instr[JWIDTH-1:0]
//   call      - jump to target and push pcplus
//   ret       - pop the top of the stack into pc (pcplus if the stack is empty)
//   instr     - current instruction (the target field is in the low bits)
//   signimm   - sign-extended branch offset in instruction words
//   pc        - registered program counter
//   pcplus    - pc + PC_STEP (combinational)
//   ret_addr  - top-of-stack value, 0 when the stack is empty
//   ras_count - number of valid stack entries
//   ras_full  - ras_count == RAS_DEPTH
//   ras_empty - ras_count == 0
//   ras_ovf   - sticky: a call was made while the stack was full
//   ras_unf   - sticky: a ret was made while the stack was empty
module pc_sequencer #(
  parameter int DWIDTH    = 8,
  parameter int IWIDTH    = 16,
  parameter int JWIDTH    = 8,
  parameter int RAS_DEPTH = 4,
  parameter int PC_STEP   = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         stall,
  input  logic                         pcsrc,
  input  logic                         jump,
  input  logic                         call,
  input  logic                         ret,
  input  logic [IWIDTH-1:0]            instr,
  input  logic [DWIDTH-1:0]            signimm,
  output logic [DWIDTH-1:0]            pc,
  output logic [DWIDTH-1:0]            pcplus,
  output logic [DWIDTH-1:0]            ret_addr,
  output logic [$clog2(RAS_DEPTH):0]   ras_count,
  output logic                         ras_full,
  output logic                         ras_empty,
  output logic                         ras_ovf,
  output logic                         ras_unf
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;

  logic [DWIDTH-1:0] ras_mem [RAS_DEPTH];
  // wr_ptr is the slot the next push writes; the top of stack sits just below.
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     top_idx;
  logic [CW-1:0]     count_q;

  logic              do_ret;
  logic              do_call;
  logic              do_jump;
  logic              do_branch;
  logic [DWIDTH-1:0] target;
  logic [DWIDTH-1:0] next_pc;

  assign pcplus  = pc + DWIDTH'(PC_STEP);
  assign target  = DWIDTH'(instr[JWIDTH-1:0]);
  assign top_idx = wr_ptr - PW'(1);

  // Outputs derived purely from registered state.
  assign ras_count = count_q;
  assign ras_full  = (count_q == CW'(RAS_DEPTH));
  assign ras_empty = (count_q == '0);
  assign ret_addr  = ras_empty ? '0 : ras_mem[top_idx];

  // Priority decode: each control is masked by everything above it.
  assign do_ret    = !stall && ret;
  assign do_call   = !stall && !ret && call;
  assign do_jump   = !stall && !ret && !call && jump;
  assign do_branch = !stall && !ret && !call && !jump && pcsrc;

  always_comb begin
    next_pc = pcplus;
    if (stall) begin
      next_pc = pc;
    end else if (do_ret) begin
      // An empty-stack ret falls through to the sequential address.
      next_pc = ras_empty ? pcplus : ret_addr;
    end else if (do_call || do_jump) begin
      next_pc = target;
    end else if (do_branch) begin
      next_pc = pcplus + (signimm << 1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc      <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
      ras_ovf <= 1'b0;
      ras_unf <= 1'b0;
    end else begin
      pc <= next_pc;
      if (do_ret) begin
        if (ras_empty) begin
          ras_unf <= 1'b1;
        end else begin
          wr_ptr  <= top_idx;
          count_q <= count_q - CW'(1);
        end
      end else if (do_call) begin
        // The push always happens; when full it overwrites the oldest slot.
        wr_ptr <= wr_ptr + PW'(1);
        if (ras_full) begin
          ras_ovf <= 1'b1;
        end else begin
          count_q <= count_q + CW'(1);
        end
      end
    end
  end

  // Entry storage needs no reset: count_q == 0 hides stale contents.
  always_ff @(posedge clk) begin
    if (!reset && do_call) begin
      ras_mem[wr_ptr] <= pcplus;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: self-checking bench for pc_sequencer (DWIDTH=8,
// RAS_DEPTH=4, PC_STEP=2). Directed vector table, hand-written reset
// sequence, then randomized traffic against a queue-based reference model.
module tb_pc_sequencer;

  logic        clk;
  logic        reset;
  logic        stall, pcsrc, jump, call, ret;
  logic [15:0] instr;
  logic [7:0]  signimm;
  logic [7:0]  pc, pcplus, ret_addr;
  logic [2:0]  ras_count;
  logic        ras_full, ras_empty, ras_ovf, ras_unf;

  int checks = 0;
  int errors = 0;

  pc_sequencer #(
    .DWIDTH(8), .IWIDTH(16), .JWIDTH(8), .RAS_DEPTH(4), .PC_STEP(2)
  ) dut (
    .clk(clk), .reset(reset), .stall(stall), .pcsrc(pcsrc), .jump(jump),
    .call(call), .ret(ret), .instr(instr), .signimm(signimm),
    .pc(pc), .pcplus(pcplus), .ret_addr(ret_addr), .ras_count(ras_count),
    .ras_full(ras_full), .ras_empty(ras_empty), .ras_ovf(ras_ovf),
    .ras_unf(ras_unf)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input int e_pc, input int e_cnt,
                           input int e_ret, input int e_ovf, input int e_unf);
    check({tag, " pc"}, pc, e_pc);
    check({tag, " pcplus"}, pcplus, (e_pc + 2) & 8'hFF);
    check({tag, " ras_count"}, ras_count, e_cnt);
    check({tag, " ret_addr"}, ret_addr, e_ret);
    check({tag, " ras_full"}, ras_full, (e_cnt == 4) ? 1 : 0);
    check({tag, " ras_empty"}, ras_empty, (e_cnt == 0) ? 1 : 0);
    check({tag, " ras_ovf"}, ras_ovf, e_ovf);
    check({tag, " ras_unf"}, ras_unf, e_unf);
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic st, input logic br, input logic jp,
                       input logic cl, input logic rt, input logic [15:0] in,
                       input logic [7:0] si);
    stall = st; pcsrc = br; jump = jp; call = cl; ret = rt;
    instr = in; signimm = si;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
    reset = 1'b0;
  endtask

  // ---------------- reference model ----------------
  int m_pc;
  int m_q[$];
  int m_ovf, m_unf;

  task automatic model_reset();
    m_pc = 0; m_q = {}; m_ovf = 0; m_unf = 0;
  endtask

  task automatic model_step(input logic st, input logic br, input logic jp,
                            input logic cl, input logic rt, input int tgt,
                            input int si);
    if (st) return;
    if (rt) begin
      if (m_q.size() > 0) m_pc = m_q.pop_back();
      else begin
        m_pc = (m_pc + 2) % 256;
        m_unf = 1;
      end
    end else if (cl) begin
      m_q.push_back((m_pc + 2) % 256);
      if (m_q.size() > 4) begin
        void'(m_q.pop_front());
        m_ovf = 1;
      end
      m_pc = tgt;
    end else if (jp) begin
      m_pc = tgt;
    end else if (br) begin
      // signimm is two's complement in words; work in plain integers.
      m_pc = (m_pc + 2 + 2 * ((si >= 128) ? si - 256 : si)) & 255;
    end else begin
      m_pc = (m_pc + 2) % 256;
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic       st, br, jp, cl, rt;
    logic [7:0] tgt;
    logic [7:0] si;
    int         e_pc, e_cnt, e_ret, e_ovf, e_unf;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic st, br, jp, cl, rt,
                              input logic [7:0] tgt, input logic [7:0] si,
                              input int e_pc, e_cnt, e_ret, e_ovf, e_unf);
    vec_t v;
    v.st = st; v.br = br; v.jp = jp; v.cl = cl; v.rt = rt;
    v.tgt = tgt; v.si = si;
    v.e_pc = e_pc; v.e_cnt = e_cnt; v.e_ret = e_ret;
    v.e_ovf = e_ovf; v.e_unf = e_unf;
    return v;
  endfunction

  initial begin
    //                  st br jp cl rt tgt    si     pc    cnt ret  ovf unf
    tbl.push_back(mk(0, 0, 0, 0, 0, 8'h00, 8'h00, 'h02, 0, 'h00, 0, 0)); // idle
    tbl.push_back(mk(0, 0, 0, 0, 0, 8'h00, 8'h00, 'h04, 0, 'h00, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 8'h00, 8'h00, 'h06, 0, 'h00, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 8'hFE, 8'h00, 'hFE, 0, 'h00, 0, 0)); // to 0xFE
    tbl.push_back(mk(0, 0, 0, 0, 0, 8'h00, 8'h00, 'h00, 0, 'h00, 0, 0)); // wrap
    tbl.push_back(mk(0, 0, 1, 0, 0, 8'h10, 8'h00, 'h10, 0, 'h00, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 8'h00, 8'hFD, 'h0C, 0, 'h00, 0, 0)); // branch back
    tbl.push_back(mk(0, 0, 1, 0, 0, 8'h10, 8'h00, 'h10, 0, 'h00, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 8'h40, 8'hFD, 'h40, 0, 'h00, 0, 0)); // jump > pcsrc
    tbl.push_back(mk(0, 0, 1, 0, 0, 8'h20, 8'h00, 'h20, 0, 'h00, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 8'h80, 8'h00, 'h80, 1, 'h22, 0, 0)); // call
    tbl.push_back(mk(0, 0, 0, 0, 1, 8'h00, 8'h00, 'h22, 0, 'h00, 0, 0)); // ret
    tbl.push_back(mk(0, 0, 1, 0, 0, 8'h00, 8'h00, 'h00, 0, 'h00, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 8'h10, 8'h00, 'h10, 1, 'h02, 0, 0)); // 5 calls
    tbl.push_back(mk(0, 0, 0, 1, 0, 8'h20, 8'h00, 'h20, 2, 'h12, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 8'h30, 8'h00, 'h30, 3, 'h22, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 8'h40, 8'h00, 'h40, 4, 'h32, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 8'h50, 8'h00, 'h50, 4, 'h42, 1, 0)); // overflow
    tbl.push_back(mk(0, 0, 0, 0, 1, 8'h00, 8'h00, 'h42, 3, 'h32, 1, 0)); // 4 rets
    tbl.push_back(mk(0, 0, 0, 0, 1, 8'h00, 8'h00, 'h32, 2, 'h22, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 8'h00, 8'h00, 'h22, 1, 'h12, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 8'h00, 8'h00, 'h12, 0, 'h00, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 8'h00, 8'h00, 'h14, 0, 'h00, 1, 1)); // underflow
    tbl.push_back(mk(1, 0, 0, 1, 1, 8'h77, 8'h00, 'h14, 0, 'h00, 1, 1)); // stall
    tbl.push_back(mk(0, 0, 0, 1, 0, 8'h60, 8'h00, 'h60, 1, 'h16, 1, 1));
    tbl.push_back(mk(1, 1, 1, 1, 1, 8'h77, 8'h05, 'h60, 1, 'h16, 1, 1)); // stall
    tbl.push_back(mk(0, 0, 0, 1, 1, 8'h70, 8'h00, 'h16, 0, 'h00, 1, 1)); // ret > call
  end

  // ---------------- main test ----------------
  initial begin
    reset = 1'b0;
    stall = 1'b0; pcsrc = 1'b0; jump = 1'b0; call = 1'b0; ret = 1'b0;
    instr = '0; signimm = '0;
    #2;

    // Reset state
    do_reset();
    check_all("reset", 'h00, 0, 'h00, 0, 0);

    // Directed table; upper instr bits are junk to confirm they are ignored.
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].st, tbl[i].br, tbl[i].jp, tbl[i].cl, tbl[i].rt,
            {8'hA5, tbl[i].tgt}, tbl[i].si);
      check_all($sformatf("vec%0d", i), tbl[i].e_pc, tbl[i].e_cnt,
                tbl[i].e_ret, tbl[i].e_ovf, tbl[i].e_unf);
    end

    // Reset mid-operation with count=3, ovf=1 and stall held high.
    do_reset();
    for (int i = 0; i < 5; i++)
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000 | 8'(i * 16 + 16), 8'h00);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0, 8'h0);
    check_all("pre_reset", 'h42, 3, 'h32, 1, 0);
    stall = 1'b1; call = 1'b1; ret = 1'b1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_all("mid_reset", 'h00, 0, 'h00, 0, 0);
    // A ret right after reset must see an empty stack, not stale entries.
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0, 8'h0);
    check_all("post_reset_ret", 'h02, 0, 'h00, 0, 1);

    // Randomized traffic against the reference model.
    do_reset();
    model_reset();
    for (int n = 0; n < 600; n++) begin
      logic st, br, jp, cl, rt;
      logic [15:0] in;
      logic [7:0] si;
      if ($urandom_range(0, 99) < 2) begin
        do_reset();
        model_reset();
      end
      st = ($urandom_range(0, 9) == 0);
      br = ($urandom_range(0, 3) == 0);
      jp = ($urandom_range(0, 5) == 0);
      cl = ($urandom_range(0, 3) == 0);
      rt = ($urandom_range(0, 3) == 0);
      in = 16'($urandom);
      si = 8'($urandom);
      model_step(st, br, jp, cl, rt, int'(in[7:0]), int'(si));
      drive(st, br, jp, cl, rt, in, si);
      check_all($sformatf("rand%0d", n), m_pc, m_q.size(),
                (m_q.size() > 0) ? m_q[$] : 0, m_ovf, m_unf);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
